// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM port-A arbiter: default widths,
// owner encoding and FSM state encoding.
package sram_pkg;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 24;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_R0   = 2'b01;
   localparam logic [1:0] OWN_R1   = 2'b10;

   // State codes equal the owner codes so the owner port is the state register.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_OWN0 = 2'b01,
      ST_OWN1 = 2'b10
   } state_e;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// the requester named by rr_ptr.
module sram_rr_arb2 (
   input  logic [1:0] valid,
   input  logic       rr_ptr,
   output logic       winner
);

   always_comb begin
      winner = rr_ptr;
      if (valid == 2'b01) begin
         winner = 1'b0;
      end else if (valid == 2'b10) begin
         winner = 1'b1;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM port A between the host loader (req0) and the operand fetcher
// (req1): burst-locked round-robin grant, idle-hold timeout, tagged responses.
module sram_port_arbiter
   import sram_pkg::*;
#(
   parameter int AW           = AW_DEF,
   parameter int DW           = DW_DEF,
   parameter int HOLD_TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          r0_valid,
   output logic          r0_ready,
   input  logic          r0_we,
   input  logic          r0_last,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   output logic          r0_rsp_valid,
   output logic [DW-1:0] r0_rsp_data,
   input  logic          r1_valid,
   output logic          r1_ready,
   input  logic          r1_we,
   input  logic          r1_last,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   output logic          r1_rsp_valid,
   output logic [DW-1:0] r1_rsp_data,
   output logic          sram_en,
   output logic          sram_we,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_din,
   input  logic [DW-1:0] sram_dout,
   output logic [1:0]    owner
);

   localparam int             CW       = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0]  HOLD_LIM = CW'(HOLD_TIMEOUT);
   localparam bit             HOLD_ON  = (HOLD_TIMEOUT != 0);

   state_e               state_q, state_d;
   logic                 rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [1:0]           rsp_vld_q, rsp_vld_d;
   logic [1:0][DW-1:0]   rsp_hold_q, rsp_hold_d;

   logic                 own0, own1;
   logic                 cur_valid, cur_last, cur_we, other_valid;
   logic                 xfer, timeout_hit, release_grant, winner;
   logic [CW-1:0]        cnt_inc;

   sram_rr_arb2 u_arb (
      .valid  ({r1_valid, r0_valid}),
      .rr_ptr (rr_ptr_q),
      .winner (winner)
   );

   assign own0 = (state_q == ST_OWN0);
   assign own1 = (state_q == ST_OWN1);

   assign cur_valid   = own1 ? r1_valid : (own0 & r0_valid);
   assign cur_last    = own1 ? r1_last  : r0_last;
   assign cur_we      = own1 ? r1_we    : r0_we;
   assign other_valid = own1 ? r0_valid : r1_valid;

   assign r0_ready  = own0;
   assign r1_ready  = own1;
   assign owner     = state_q;
   assign xfer      = cur_valid;
   assign sram_en   = xfer;
   assign sram_we   = xfer & cur_we;
   assign sram_addr = own1 ? r1_addr  : r0_addr;
   assign sram_din  = own1 ? r1_wdata : r0_wdata;

   assign cnt_inc       = cnt_q + CW'(1);
   assign timeout_hit   = HOLD_ON && (own0 || own1) && !cur_valid && (cnt_inc == HOLD_LIM);
   assign release_grant = (xfer & cur_last) | timeout_hit;

   // Response data is the SRAM's registered output in the flagged cycle, and
   // the captured copy afterwards.
   assign r0_rsp_valid = rsp_vld_q[0];
   assign r1_rsp_valid = rsp_vld_q[1];
   assign r0_rsp_data  = rsp_vld_q[0] ? sram_dout : rsp_hold_q[0];
   assign r1_rsp_data  = rsp_vld_q[1] ? sram_dout : rsp_hold_q[1];

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      cnt_d      = cnt_q;
      rsp_vld_d  = 2'b00;
      rsp_hold_d = rsp_hold_q;

      if (xfer && !cur_we) begin
         rsp_vld_d = own1 ? 2'b10 : 2'b01;
      end
      for (int i = 0; i < 2; i++) begin
         if (rsp_vld_q[i]) begin
            rsp_hold_d[i] = sram_dout;
         end
      end

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (r0_valid || r1_valid) begin
               state_d = winner ? ST_OWN1 : ST_OWN0;
            end
         end
         ST_OWN0, ST_OWN1: begin
            if (release_grant) begin
               rr_ptr_d = own0;
               cnt_d    = '0;
               if (other_valid) begin
                  state_d = own0 ? ST_OWN1 : ST_OWN0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (xfer) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= 1'b0;
         cnt_q      <= '0;
         rsp_vld_q  <= 2'b00;
         rsp_hold_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_hold_q <= rsp_hold_d;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vector table, hand sequences for the
// timeout and mid-burst reset, then randomized traffic against a cycle model.
module tb_sram_port_arbiter;
   import sram_pkg::*;

   localparam int AW   = 8;
   localparam int DW   = 24;
   localparam int HOLD = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          r0_valid = 1'b0, r0_we = 1'b0, r0_last = 1'b0;
   logic [AW-1:0] r0_addr = '0;
   logic [DW-1:0] r0_wdata = '0;
   logic          r1_valid = 1'b0, r1_we = 1'b0, r1_last = 1'b0;
   logic [AW-1:0] r1_addr = '0;
   logic [DW-1:0] r1_wdata = '0;
   logic          r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
   logic [DW-1:0] r0_rsp_data, r1_rsp_data;
   logic          sram_en, sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din;
   logic [DW-1:0] sram_dout;
   logic [1:0]    owner;

   int n_checks = 0;
   int n_errors = 0;
   int n_wr     = 0;

   sram_port_arbiter #(.AW(AW), .DW(DW), .HOLD_TIMEOUT(HOLD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .r0_valid     (r0_valid),
      .r0_ready     (r0_ready),
      .r0_we        (r0_we),
      .r0_last      (r0_last),
      .r0_addr      (r0_addr),
      .r0_wdata     (r0_wdata),
      .r0_rsp_valid (r0_rsp_valid),
      .r0_rsp_data  (r0_rsp_data),
      .r1_valid     (r1_valid),
      .r1_ready     (r1_ready),
      .r1_we        (r1_we),
      .r1_last      (r1_last),
      .r1_addr      (r1_addr),
      .r1_wdata     (r1_wdata),
      .r1_rsp_valid (r1_rsp_valid),
      .r1_rsp_data  (r1_rsp_data),
      .sram_en      (sram_en),
      .sram_we      (sram_we),
      .sram_addr    (sram_addr),
      .sram_din     (sram_din),
      .sram_dout    (sram_dout),
      .owner        (owner)
   );

   always #5 clk = ~clk;

   // Port-A SRAM model with registered read output.
   logic [DW-1:0] mem [256];
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we) begin
            mem[sram_addr] <= sram_din;
            n_wr <= n_wr + 1;
         end else begin
            sram_dout <= mem[sram_addr];
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic          rst_n;
      logic          v0, we0, l0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          v1, we1, l1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic [1:0]    own;
      logic          en, we;
      logic [AW-1:0] addr;
      logic          rv0, rv1;
      logic [DW-1:0] rd;
   } vec_t;

   function automatic vec_t mk(input logic rs, input logic v0, input logic we0, input logic l0,
                               input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic we1, input logic l1,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic [1:0] own, input logic en, input logic we,
                               input logic [AW-1:0] addr, input logic rv0, input logic rv1,
                               input logic [DW-1:0] rd);
      vec_t v;
      v.rst_n = rs;  v.v0 = v0; v.we0 = we0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
      v.v1 = v1; v.we1 = we1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
      v.own = own; v.en = en; v.we = we; v.addr = addr;
      v.rv0 = rv0; v.rv1 = rv1; v.rd = rd;
      return v;
   endfunction

   task automatic clear_inputs();
      r0_valid = 1'b0; r0_we = 1'b0; r0_last = 1'b0; r0_addr = '0; r0_wdata = '0;
      r1_valid = 1'b0; r1_we = 1'b0; r1_last = 1'b0; r1_addr = '0; r1_wdata = '0;
   endtask

   task automatic run_table();
      vec_t tbl[$];
      //                 rs v0 w0 l0 a0 d0        v1 w1 l1 a1 d1  own     en we ad rv0 rv1 rd
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, OWN_NONE, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 24'h11,   0, 0, 0, 0, 0, OWN_NONE, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 24'h11,   0, 0, 0, 0, 0, OWN_R0,   1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 1, 24'h22,   0, 0, 0, 0, 0, OWN_R0,   1, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 2, 24'h33,   0, 0, 0, 0, 0, OWN_R0,   1, 1, 2, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 1, 3, 24'h44,   0, 0, 0, 0, 0, OWN_R0,   1, 1, 3, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, OWN_NONE, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, OWN_NONE, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4, 24'h55,   1, 0, 0, 0, 0, OWN_NONE, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 4, 24'h55,   1, 0, 0, 0, 0, OWN_R0,   1, 1, 4, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 1, 5, 24'h66,   1, 0, 0, 0, 0, OWN_R0,   1, 1, 5, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0, OWN_R1,   1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,        1, 0, 0, 1, 0, OWN_R1,   1, 0, 1, 0, 1, 24'h11));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,        1, 0, 0, 2, 0, OWN_R1,   1, 0, 2, 0, 1, 24'h22));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,        1, 0, 1, 3, 0, OWN_R1,   1, 0, 3, 0, 1, 24'h33));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, OWN_NONE, 0, 0, 0, 0, 1, 24'h44));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, OWN_NONE, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 1, 5, 0,        1, 0, 1, 4, 0, OWN_NONE, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 1, 5, 0,        1, 0, 1, 4, 0, OWN_R0,   1, 0, 5, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,        1, 0, 1, 4, 0, OWN_R1,   1, 0, 4, 1, 0, 24'h66));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, OWN_NONE, 0, 0, 0, 0, 1, 24'h55));

      foreach (tbl[i]) begin
         @(negedge clk);
         rst_n = tbl[i].rst_n;
         r0_valid = tbl[i].v0; r0_we = tbl[i].we0; r0_last = tbl[i].l0;
         r0_addr = tbl[i].a0;  r0_wdata = tbl[i].d0;
         r1_valid = tbl[i].v1; r1_we = tbl[i].we1; r1_last = tbl[i].l1;
         r1_addr = tbl[i].a1;  r1_wdata = tbl[i].d1;
         #1;
         check($sformatf("s%0d owner", i), owner, tbl[i].own);
         check($sformatf("s%0d r0_ready", i), r0_ready, tbl[i].own == OWN_R0);
         check($sformatf("s%0d r1_ready", i), r1_ready, tbl[i].own == OWN_R1);
         check($sformatf("s%0d sram_en", i), sram_en, tbl[i].en);
         if (tbl[i].en) begin
            check($sformatf("s%0d sram_we", i), sram_we, tbl[i].we);
            check($sformatf("s%0d sram_addr", i), sram_addr, tbl[i].addr);
            if (tbl[i].we) begin
               check($sformatf("s%0d sram_din", i), sram_din,
                     (tbl[i].own == OWN_R0) ? tbl[i].d0 : tbl[i].d1);
            end
         end
         check($sformatf("s%0d r0_rsp_valid", i), r0_rsp_valid, tbl[i].rv0);
         check($sformatf("s%0d r1_rsp_valid", i), r1_rsp_valid, tbl[i].rv1);
         if (tbl[i].rv0) check($sformatf("s%0d r0_rsp_data", i), r0_rsp_data, tbl[i].rd);
         if (tbl[i].rv1) check($sformatf("s%0d r1_rsp_data", i), r1_rsp_data, tbl[i].rd);
      end
   endtask

   // mem[1]=0x22 from the table; reset lands while r1 has another read beat on the port.
   task automatic seq_reset_mid_burst();
      int wr_before;
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
      r1_valid = 1'b1; r1_addr = 8'd1;
      #1 check("rst_mid idle owner", owner, OWN_NONE);
      @(negedge clk);
      #1 check("rst_mid owner r1", owner, OWN_R1);
      check("rst_mid beat en", sram_en, 1'b1);
      @(negedge clk);
      wr_before = n_wr;
      rst_n = 1'b0;
      r1_addr = 8'd2;
      #1 check("rst_mid rsp before reset", r1_rsp_valid, 1'b1);
      check("rst_mid rsp data", r1_rsp_data, 24'h22);
      @(negedge clk);
      rst_n = 1'b1;
      r1_valid = 1'b0;
      #1 check("rst_mid owner after", owner, OWN_NONE);
      check("rst_mid no r1 rsp", r1_rsp_valid, 1'b0);
      check("rst_mid no r0 rsp", r0_rsp_valid, 1'b0);
      check("rst_mid r1 rsp data reset", r1_rsp_data, 24'h0);
      check("rst_mid no sram write", n_wr - wr_before, 0);
   endtask

   task automatic seq_timeout();
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 8'd8; r0_wdata = 24'h77;
      r1_valid = 1'b1; r1_addr = 8'd0;
      #1 check("to idle owner", owner, OWN_NONE);
      @(negedge clk);
      #1 check("to r0 owns", owner, OWN_R0);
      check("to r0 beat", sram_en, 1'b1);
      @(negedge clk);
      r0_valid = 1'b0;
      for (int k = 1; k <= HOLD; k++) begin
         #1;
         check($sformatf("to held %0d", k), owner, OWN_R0);
         check($sformatf("to held en %0d", k), sram_en, 1'b0);
         @(negedge clk);
      end
      #1 check("to forced release", owner, OWN_R1);
      check("to r1_ready", r1_ready, 1'b1);
      @(negedge clk);
      r1_last = 1'b1;
      @(negedge clk);
      clear_inputs();
      #1 check("to back idle", owner, OWN_NONE);
      @(negedge clk);
      r0_valid = 1'b1; r0_last = 1'b1; r0_addr = 8'd8;
      r1_valid = 1'b1; r1_last = 1'b1; r1_addr = 8'd0;
      @(negedge clk);
      #1 check("to rr points r0", owner, OWN_R0);
      @(negedge clk);
      r0_valid = 1'b0;
      #1 check("to r1 after r0 single", owner, OWN_R1);
      check("to r0 rsp", r0_rsp_valid, 1'b1);
      check("to r0 rsp data", r0_rsp_data, 24'h77);
      @(negedge clk);
      r1_valid = 1'b0;
      #1 check("to final idle", owner, OWN_NONE);
      check("to r1 rsp data", r1_rsp_data, 24'h11);
   endtask

   // Cycle model: owner (0 none, 1 req0, 2 req1), rr preference, idle count,
   // and a one-deep queue of pending read responses with expected data.
   task automatic run_random(input int cycles);
      int            m_own, m_rr, m_idle, me, pct0, pct1;
      bit            p_vld, p_known, e_en, rel, ov, cl, cw;
      int            p_tag;
      logic [DW-1:0] p_data;
      logic [DW-1:0] mmem [256];
      bit            known [256];
      logic [DW-1:0] last_rsp [2];
      bit            last_known [2];
      logic [AW-1:0] ca;
      logic [DW-1:0] cd;
      logic          v [2];
      logic [DW-1:0] rdat [2];

      @(negedge clk);
      clear_inputs();
      rst_n = 1'b0;
      m_own = 0; m_rr = 0; m_idle = 0; p_vld = 0; p_known = 0; p_tag = 0; p_data = '0;
      pct0 = 50; pct1 = 50;
      foreach (known[i]) known[i] = 1'b0;
      for (int i = 0; i < 2; i++) begin last_rsp[i] = '0; last_known[i] = 1'b1; end

      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         rst_n = 1'b1;
         if (c % 150 == 0) begin
            pct0 = (($urandom_range(0, 2) == 0) ? 5 : ($urandom_range(0, 1) ? 50 : 95));
            pct1 = (($urandom_range(0, 2) == 0) ? 5 : ($urandom_range(0, 1) ? 50 : 95));
         end
         r0_valid = ($urandom_range(0, 99) < pct0);
         r0_we = $urandom_range(0, 1); r0_last = ($urandom_range(0, 3) == 0);
         r0_addr = AW'($urandom_range(0, 15)); r0_wdata = DW'($urandom);
         r1_valid = ($urandom_range(0, 99) < pct1);
         r1_we = $urandom_range(0, 1); r1_last = ($urandom_range(0, 3) == 0);
         r1_addr = AW'($urandom_range(0, 15)); r1_wdata = DW'($urandom);
         #1;

         v[0] = r0_valid; v[1] = r1_valid;
         rdat[0] = r0_rsp_data; rdat[1] = r1_rsp_data;
         me = m_own - 1;
         e_en = (m_own != 0) && v[me];
         cw = (m_own == 2) ? r1_we : r0_we;
         cl = (m_own == 2) ? r1_last : r0_last;
         ca = (m_own == 2) ? r1_addr : r0_addr;
         cd = (m_own == 2) ? r1_wdata : r0_wdata;

         check($sformatf("rnd%0d owner", c), owner, m_own);
         check($sformatf("rnd%0d r0_ready", c), r0_ready, m_own == 1);
         check($sformatf("rnd%0d r1_ready", c), r1_ready, m_own == 2);
         check($sformatf("rnd%0d sram_en", c), sram_en, e_en);
         if (e_en) begin
            check($sformatf("rnd%0d sram_we", c), sram_we, cw);
            check($sformatf("rnd%0d sram_addr", c), sram_addr, ca);
            if (cw) check($sformatf("rnd%0d sram_din", c), sram_din, cd);
         end
         check($sformatf("rnd%0d r0_rsp_valid", c), r0_rsp_valid, p_vld && p_tag == 0);
         check($sformatf("rnd%0d r1_rsp_valid", c), r1_rsp_valid, p_vld && p_tag == 1);
         for (int i = 0; i < 2; i++) begin
            if (p_vld && p_tag == i) begin
               last_rsp[i] = p_data;
               last_known[i] = p_known;
            end
            if (last_known[i]) check($sformatf("rnd%0d r%0d_rsp_data", c, i), rdat[i], last_rsp[i]);
         end

         p_vld = e_en && !cw;
         p_tag = me;
         p_data = mmem[ca];
         p_known = known[ca];
         if (e_en && cw) begin
            mmem[ca] = cd;
            known[ca] = 1'b1;
         end

         if (m_own == 0) begin
            m_idle = 0;
            if (v[0] && v[1]) m_own = m_rr + 1;
            else if (v[0]) m_own = 1;
            else if (v[1]) m_own = 2;
         end else begin
            ov = v[1 - me];
            rel = 1'b0;
            if (e_en) begin
               rel = cl;
               m_idle = 0;
            end else begin
               m_idle++;
               rel = (m_idle == HOLD);
            end
            if (rel) begin
               m_rr = 1 - me;
               m_own = ov ? (2 - me) : 0;
               m_idle = 0;
            end
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      run_table();
      seq_reset_mid_burst();
      seq_timeout();
      run_random(2000);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
